// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: per-stage stall/flush strobes, PC redirect,
// instruction-fetch refill tracking, hung-memory watchdog and perf counters.
module hazard_ctrl #(
  parameter int FETCH_LAT   = 2,
  parameter int MEM_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        no_forwarding_data,
  input  logic        mem_req_MEMP,
  input  logic        mem_ready_MEMP,
  input  logic        jump_EXB,
  input  logic        imem_ready,
  output logic [7:0]  stall,
  output logic [7:0]  flush,
  output logic        pc_redirect,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] redirect_cnt
);

  // state    | meaning
  // RUN      | normal flow, no outstanding refill or memory hold
  // MEM_WAIT | data memory is holding MEMP and everything younger
  // REFILL   | fetch pipe still returning wrong-path words after a redirect
  typedef enum logic [1:0] {RUN, MEM_WAIT, REFILL} state_t;

  localparam logic [3:0]  REFILL_LOAD = 4'(FETCH_LAT - 1);
  localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);

  state_t      state;
  logic [3:0]  refill_cnt;
  logic [15:0] wait_cnt;
  logic [15:0] wait_inc;
  logic        timeout_q;
  logic        mem_hold;

  assign mem_hold = mem_req_MEMP && !mem_ready_MEMP;
  assign wait_inc = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
  assign mem_timeout = timeout_q && !rst;

  always_comb begin
    stall       = 8'h00;
    flush       = 8'h00;
    pc_redirect = 1'b0;
    if (rst) begin
      flush = 8'hFF;
    end else begin
      if (mem_hold) begin
        stall = 8'h3F;
        flush = 8'h40;
      end else if (jump_EXB) begin
        flush       = 8'h0F;
        pc_redirect = 1'b1;
      end else if (no_forwarding_data) begin
        stall = 8'h07;
        flush = 8'h08;
      end else if (!imem_ready) begin
        stall = 8'h01;
        flush = 8'h02;
      end
      // Wrong-path words still in flight from instruction memory are discarded.
      if (state == REFILL) flush[1] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      refill_cnt   <= 4'd0;
      wait_cnt     <= 16'd0;
      timeout_q    <= 1'b0;
      stall_cnt    <= 32'd0;
      redirect_cnt <= 32'd0;
    end else begin
      if (|stall)      stall_cnt    <= stall_cnt + 32'd1;
      if (pc_redirect) redirect_cnt <= redirect_cnt + 32'd1;

      case (state)
        RUN: begin
          if (mem_hold) begin
            state    <= MEM_WAIT;
            wait_cnt <= 16'd1;
          end else if (jump_EXB && FETCH_LAT > 1) begin
            state      <= REFILL;
            refill_cnt <= REFILL_LOAD;
          end
        end
        MEM_WAIT: begin
          if (mem_hold) begin
            wait_cnt <= wait_inc;
            if (wait_inc == TIMEOUT_VAL) timeout_q <= 1'b1;
          end else if (jump_EXB) begin
            refill_cnt <= REFILL_LOAD;
            state      <= (FETCH_LAT > 1) ? REFILL : RUN;
          end else if (refill_cnt != 4'd0) begin
            state <= REFILL;
          end else begin
            state <= RUN;
          end
        end
        REFILL: begin
          // A hold freezes refill_cnt so the refill resumes afterwards.
          if (mem_hold) begin
            state    <= MEM_WAIT;
            wait_cnt <= 16'd1;
          end else if (jump_EXB) begin
            refill_cnt <= REFILL_LOAD;
            state      <= (FETCH_LAT > 1) ? REFILL : RUN;
          end else begin
            refill_cnt <= refill_cnt - 4'd1;
            if (refill_cnt <= 4'd1) state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FETCH_LAT=3, MEM_TIMEOUT=8) with an
// expected-response queue popped mid-cycle against the DUT outputs.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        no_forwarding_data, mem_req_MEMP, mem_ready_MEMP, jump_EXB, imem_ready;
  logic [7:0]  stall, flush;
  logic        pc_redirect, mem_timeout;
  logic [31:0] stall_cnt, redirect_cnt;

  hazard_ctrl #(.FETCH_LAT(3), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .no_forwarding_data(no_forwarding_data),
    .mem_req_MEMP(mem_req_MEMP), .mem_ready_MEMP(mem_ready_MEMP),
    .jump_EXB(jump_EXB), .imem_ready(imem_ready),
    .stall(stall), .flush(flush), .pc_redirect(pc_redirect),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] stall;
    logic [7:0] flush;
    logic       redir;
    logic       tmo;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One cycle: drive inputs, queue the expectation, compare mid-cycle, advance.
  task automatic cyc(input logic r, input logic nfd, input logic req, input logic rdy,
                     input logic jmp, input logic imr, input logic [7:0] es,
                     input logic [7:0] ef, input logic er, input logic et, input string tag);
    exp_t e;
    rst = r; no_forwarding_data = nfd; mem_req_MEMP = req; mem_ready_MEMP = rdy;
    jump_EXB = jmp; imem_ready = imr;
    e.stall = es; e.flush = ef; e.redir = er; e.tmo = et; e.tag = tag;
    sb.push_back(e);
    #3;
    e = sb.pop_front();
    chk({e.tag, ".stall"}, {24'd0, stall}, {24'd0, e.stall});
    chk({e.tag, ".flush"}, {24'd0, flush}, {24'd0, e.flush});
    chk({e.tag, ".redir"}, {31'd0, pc_redirect}, {31'd0, e.redir});
    chk({e.tag, ".tmo"},   {31'd0, mem_timeout}, {31'd0, e.tmo});
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic [7:0] ef, input logic et, input string tag);
    cyc(0, 0, 0, 0, 0, 1, 8'h00, ef, 0, et, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; no_forwarding_data = 0; mem_req_MEMP = 0; mem_ready_MEMP = 0;
    jump_EXB = 0; imem_ready = 1;
    @(posedge clk); #1;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      logic [4:0] rnd;
      rnd = 5'($urandom);
      cyc(1, rnd[0], rnd[1], rnd[2], rnd[3], rnd[4], 8'h00, 8'hFF, 0, 0, "reset");
    end
    idle(8'h00, 0, "post_reset");
    chk("stall_cnt_reset", stall_cnt, 32'd0);
    chk("redirect_cnt_reset", redirect_cnt, 32'd0);

    // Load-use hazard
    cyc(0, 1, 0, 0, 0, 1, 8'h07, 8'h08, 0, 0, "load_use0");
    cyc(0, 1, 0, 0, 0, 1, 8'h07, 8'h08, 0, 0, "load_use1");
    idle(8'h00, 0, "load_use_done");
    chk("stall_cnt_load_use", stall_cnt, 32'd2);

    // Redirect and refill
    cyc(0, 0, 0, 0, 1, 1, 8'h00, 8'h0F, 1, 0, "redirect");
    idle(8'h02, 0, "refill0");
    idle(8'h02, 0, "refill1");
    idle(8'h00, 0, "refill_done");
    chk("redirect_cnt_1", redirect_cnt, 32'd1);

    // Memory wait with pending jump
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 1, 0, 1, 1, 8'h3F, 8'h40, 0, 0, "mem_hold_jump");
    cyc(0, 0, 1, 1, 1, 1, 8'h00, 8'h0F, 1, 0, "mem_ready_jump");
    idle(8'h02, 0, "mw_refill0");
    idle(8'h02, 0, "mw_refill1");
    idle(8'h00, 0, "mw_refill_done");
    chk("stall_cnt_mem", stall_cnt, 32'd6);
    chk("redirect_cnt_2", redirect_cnt, 32'd2);

    // Timeout
    for (int i = 0; i < 8; i++)
      cyc(0, 0, 1, 0, 0, 1, 8'h3F, 8'h40, 0, 0, "timeout_hold");
    cyc(0, 0, 1, 1, 0, 1, 8'h00, 8'h00, 0, 1, "timeout_ready");
    idle(8'h00, 1, "timeout_sticky");
    chk("stall_cnt_timeout", stall_cnt, 32'd14);

    // Priority mix
    cyc(0, 1, 0, 0, 1, 0, 8'h00, 8'h0F, 1, 1, "prio_mix");
    cyc(0, 0, 0, 0, 0, 0, 8'h01, 8'h02, 0, 1, "refill_imem_miss");
    idle(8'h02, 1, "prio_refill1");
    idle(8'h00, 1, "prio_done");
    chk("redirect_cnt_3", redirect_cnt, 32'd3);
    chk("stall_cnt_prio", stall_cnt, 32'd15);

    // Jump during REFILL reloads the refill count
    cyc(0, 0, 0, 0, 1, 1, 8'h00, 8'h0F, 1, 1, "jump_a");
    idle(8'h02, 1, "reload_r0");
    cyc(0, 0, 0, 0, 1, 1, 8'h00, 8'h0F, 1, 1, "jump_in_refill");
    idle(8'h02, 1, "reload_r1");
    idle(8'h02, 1, "reload_r2");
    idle(8'h00, 1, "reload_done");
    chk("redirect_cnt_5", redirect_cnt, 32'd5);

    // Reset mid-REFILL
    cyc(0, 0, 0, 0, 1, 1, 8'h00, 8'h0F, 1, 1, "jump_b");
    cyc(1, 0, 0, 0, 0, 1, 8'h00, 8'hFF, 0, 0, "reset_mid_refill");
    idle(8'h00, 0, "after_reset_run");
    chk("stall_cnt_cleared", stall_cnt, 32'd0);
    chk("redirect_cnt_cleared", redirect_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
